// File: rtl/key_ctrl_pkg.sv
// Shared constants for the front-panel key controller: FSM state encoding
// and default debounce timing for the 50 MHz board clock.
package key_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_e;

    // 20 ms of stable level at 50 MHz
    localparam int DB_CYCLES_DEFAULT = 1000000;
    localparam int DB_CNT_W_DEFAULT  = 20;

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: 2-flop synchronizer, stable-level debounce counter
// and a registered one-cycle press event on the debounced 1->0 transition.
module key_debounce
    import key_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = DB_CNT_W_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_press
);

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic             r_stable_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             w_fall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_key_n;
            r_s2 <= r_s1;
        end
    end

    // Any return to the accepted level restarts the stability window
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b1;
        end else if (r_s2 == r_stable) begin
            r_cnt    <= '0;
        end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
            r_cnt    <= '0;
            r_stable <= r_s2;
        end else begin
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    assign w_fall = r_stable_d & ~r_stable;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stable_d <= 1'b1;
            r_press    <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
            r_press    <= w_fall;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/key_run_ctrl.sv
// Run/pause/clear control for timer_60s: two debounced keys feed a registered
// FSM that drives the timer enable level and a one-cycle clear strobe.
module key_run_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = DB_CNT_W_DEFAULT
) (
    input  logic       CLK50M,
    input  logic       sys_rst_n,
    input  logic       key_start_n,
    input  logic       key_clr_n,
    output logic       en,
    output logic       clr_pulse,
    output logic [1:0] state
);

    logic   w_start_evt;
    logic   w_clr_evt;
    state_e r_state;
    state_e w_state_nxt;
    logic   r_en;
    logic   w_en_nxt;
    logic   r_clr;
    logic   w_clr_nxt;

    key_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_start (
        .i_clk   (CLK50M),
        .i_rst_n (sys_rst_n),
        .i_key_n (key_start_n),
        .o_press (w_start_evt)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_clr (
        .i_clk   (CLK50M),
        .i_rst_n (sys_rst_n),
        .i_key_n (key_clr_n),
        .o_press (w_clr_evt)
    );

    // Clear takes priority over a start event arriving on the same cycle
    always_comb begin
        w_state_nxt = r_state;
        w_clr_nxt   = 1'b0;
        if (w_clr_evt) begin
            w_state_nxt = ST_IDLE;
            w_clr_nxt   = 1'b1;
        end else if (w_start_evt) begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_RUN;
                ST_RUN:   w_state_nxt = ST_PAUSE;
                ST_PAUSE: w_state_nxt = ST_RUN;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
        w_en_nxt = (w_state_nxt == ST_RUN);
    end

    always_ff @(posedge CLK50M or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
            r_en    <= 1'b0;
            r_clr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_en    <= w_en_nxt;
            r_clr   <= w_clr_nxt;
        end
    end

    assign en        = r_en;
    assign clr_pulse = r_clr;
    assign state     = r_state;

endmodule

// File: tb/tb_key_run_ctrl.sv
// Directed bench for key_run_ctrl with an 8-cycle debounce window.
module tb_key_run_ctrl;

    logic       clk = 1'b0;
    logic       sys_rst_n;
    logic       key_start_n;
    logic       key_clr_n;
    logic       en;
    logic       clr_pulse;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    always #10 clk = ~clk;

    key_run_ctrl #(.DB_CYCLES(8), .CNT_W(4)) dut (
        .CLK50M      (clk),
        .sys_rst_n   (sys_rst_n),
        .key_start_n (key_start_n),
        .key_clr_n   (key_clr_n),
        .en          (en),
        .clr_pulse   (clr_pulse),
        .state       (state)
    );

    typedef struct {
        string      name;
        logic       start_n;
        logic       clr_n;
        logic       exp_en;
        logic [1:0] exp_state;
        int         exp_clr;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Press for 20 cycles, release, settle 30 cycles; count clear strobes
    task automatic apply(input logic s_n, input logic c_n,
                         output int clr_cnt, output int clr_bad);
        clr_cnt = 0;
        clr_bad = 0;
        @(negedge clk);
        key_start_n = s_n;
        key_clr_n   = c_n;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) begin
                @(negedge clk);
                key_start_n = 1'b1;
                key_clr_n   = 1'b1;
            end
            @(posedge clk);
            #1;
            if (clr_pulse === 1'b1) begin
                clr_cnt++;
                if (state !== 2'b00 || en !== 1'b0) clr_bad++;
            end
        end
    endtask

    // Edges from the current negedge until en is seen high (bounded)
    task automatic wait_en(output int cyc);
        cyc = 40;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (en === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        int ccnt;
        int cbad;
        int idle_bad;
        int max_cnt;

        vecs[0] = '{"run_to_pause",   1'b0, 1'b1, 1'b0, 2'b10, 0};
        vecs[1] = '{"pause_to_run",   1'b0, 1'b1, 1'b1, 2'b01, 0};
        vecs[2] = '{"clr_from_run",   1'b1, 1'b0, 1'b0, 2'b00, 1};
        vecs[3] = '{"clr_in_idle",    1'b1, 1'b0, 1'b0, 2'b00, 1};
        vecs[4] = '{"idle_to_run",    1'b0, 1'b1, 1'b1, 2'b01, 0};
        vecs[5] = '{"run_to_pause2",  1'b0, 1'b1, 1'b0, 2'b10, 0};
        vecs[6] = '{"both_in_pause",  1'b0, 1'b0, 1'b0, 2'b00, 1};
        vecs[7] = '{"run_after_both", 1'b0, 1'b1, 1'b1, 2'b01, 0};

        // Reset held for 40 ns, keys idle
        sys_rst_n   = 1'b0;
        key_start_n = 1'b1;
        key_clr_n   = 1'b1;
        #5;
        chk("rst_en", int'(en), 0);
        chk("rst_clr", int'(clr_pulse), 0);
        chk("rst_state", int'(state), 0);
        #35;
        sys_rst_n = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (en !== 1'b0 || clr_pulse !== 1'b0 || state !== 2'b00) idle_bad++;
        end
        chk("idle_after_rst", idle_bad, 0);

        // First press: en must rise 12 edges after the key falls
        @(negedge clk);
        key_start_n = 1'b0;
        wait_en(cyc);
        chk("start_latency", cyc, 12);
        chk("start_state", int'(state), 1);
        repeat (12) @(posedge clk);
        @(negedge clk);
        key_start_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("en_after_release", int'(en), 1);
        chk("state_after_release", int'(state), 1);

        for (int v = 0; v < 8; v++) begin
            apply(vecs[v].start_n, vecs[v].clr_n, ccnt, cbad);
            chk({vecs[v].name, "_en"}, int'(en), int'(vecs[v].exp_en));
            chk({vecs[v].name, "_state"}, int'(state), int'(vecs[v].exp_state));
            chk({vecs[v].name, "_clr_cnt"}, ccnt, vecs[v].exp_clr);
            chk({vecs[v].name, "_clr_same_edge"}, cbad, 0);
        end

        // Bounce every 3 cycles in RUN: never accepted
        max_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i % 3 == 0) key_start_n = ~key_start_n;
            @(posedge clk);
            #1;
            if (int'(dut.u_start.r_cnt) > max_cnt) max_cnt = int'(dut.u_start.r_cnt);
        end
        @(negedge clk);
        key_start_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (int'(dut.u_start.r_cnt) > max_cnt) max_cnt = int'(dut.u_start.r_cnt);
        end
        chk("bounce_en", int'(en), 1);
        chk("bounce_state", int'(state), 1);
        chk("bounce_cnt_below_term", int'(max_cnt < 7), 1);

        // Async reset mid-RUN while start is held down
        @(negedge clk);
        key_start_n = 1'b0;
        repeat (5) @(posedge clk);
        #5;
        sys_rst_n = 1'b0;
        #1;
        chk("midrun_rst_en", int'(en), 0);
        chk("midrun_rst_state", int'(state), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        sys_rst_n = 1'b1;
        wait_en(cyc);
        chk("held_after_rst_latency", cyc, 12);
        chk("held_after_rst_state", int'(state), 1);
        @(negedge clk);
        key_start_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("held_after_rst_single", int'(state), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_run_ctrl.md
Name: key_run_ctrl

Overview:
Front-panel control stage directly upstream of timer_60s. Debounces two active-low push-buttons (start/pause, clear) on the 50 MHz board clock. Runs a small run/pause state machine that drives the timer's en level, and emits a one-cycle clear pulse for the timer's count-reset path.

Parameters:
DB_CYCLES, 1000000, stable cycles required before a key level is accepted (20 ms at 50 MHz); the bench overrides this to 8
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W >= DB_CYCLES

Ports:
CLK50M  input  1  system clock, 50 MHz, all logic on rising edge
sys_rst_n  input  1  asynchronous active-low reset
key_start_n  input  1  raw start/pause button, asynchronous, 0 = pressed
key_clr_n  input  1  raw clear button, asynchronous, 0 = pressed
en  output  1  count enable to timer_60s, registered level
clr_pulse  output  1  one-cycle clear strobe to timer_60s, registered
state  output  2  current FSM state for LEDs/debug: 00 IDLE, 01 RUN, 10 PAUSE

Behaviour:
- Reset (async assert, sync-to-clock release path not required):
  - en=0, clr_pulse=0, state=IDLE.
  - Synchronizer flops and debounced levels preset to 1 (released).
  - Debounce counters preset to 0.
- Per key, in order:
  - 2-flop synchronizer (s1, s2).
  - Debounce:
    - If s2 == stable: counter cleared to 0.
    - Otherwise: counter increments each cycle.
    - When counter == DB_CYCLES-1 and s2 still != stable: stable <= s2 and counter <= 0.
    - Any bounce back to stable before the terminal count clears the counter; the level is not accepted.
- Press event: one-cycle pulse when stable goes 1->0. The release edge produces no event.
- Latency:
  - Raw edge held clean to stable change: 2 + DB_CYCLES cycles.
  - Stable change to press event pulse: 1 cycle.
  - Press event to en/state/clr_pulse update: 1 cycle.
- FSM (registered):
  - IDLE: start_evt -> RUN.
  - RUN: start_evt -> PAUSE.
  - PAUSE: start_evt -> RUN.
  - Any state: clr_evt -> IDLE.
- Outputs:
  - en = 1 only in RUN. en is a register written with the next-state decode, so it changes on the same edge as state.
  - clr_pulse = 1 for exactly one cycle on the edge where clr_evt is taken, in every state including IDLE.
- Simultaneous start_evt and clr_evt in one cycle: clear wins. Result is state=IDLE, en=0, clr_pulse=1.
- Key held down: one event only. A new event requires a debounced release followed by a new debounced press.
- Both keys held: each key produces its own single event. No auto-repeat.
- Reset asserted mid-debounce or mid-run: everything returns to reset values immediately. A key still held at reset release must be seen for DB_CYCLES as pressed; the stable preset of 1 makes that a new press.
- No combinational path from key inputs to any output.

Decomposition:
- Shared package key_ctrl_pkg:
  - State encoding constants ST_IDLE=2'b00, ST_RUN=2'b01, ST_PAUSE=2'b10.
  - Default DB_CYCLES constant for 50 MHz / 20 ms.
- One natural sub-module: key_debounce, containing synchronizer, counter, stable register and press-event output.
  - Parameterized by DB_CYCLES and CNT_W.
  - Instantiated twice.
- key_run_ctrl holds only the FSM and output registers.

Test Plan (DB_CYCLES=8, 20 ns clock):
- Reset held 40 ns then released, keys idle -> en=0, clr_pulse=0, state=00 throughout 200 ns.
- key_start_n low for 20 cycles -> exactly one event; en rises 2+8+2=12 cycles after the falling edge; state=01; stays 1 after release.
- Second clean start press while RUN -> en=0, state=10. Third press -> en=1, state=01.
- key_start_n toggled every 3 cycles for 30 cycles, then held high -> no event; en and state unchanged; debounce counter never reaches 7.
- RUN, then key_clr_n low for 20 cycles -> clr_pulse high for exactly 1 cycle; en=0, state=00. Repeat in IDLE -> clr_pulse again 1 cycle, state stays 00.
- Both keys released/pressed on the same cycle in PAUSE -> events coincide; state=00, en=0, clr_pulse=1.
- Reset mid-RUN with start held -> en=0 immediately (async). After release, start still held -> one new event, en=1 12 cycles after reset release.
